// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   - ALU operation codes (ALU control field encoding), used by the ALU and by
//     the iterative multiply/divide unit.
//   - State encoding of the multiply/divide sequencer.
package cpu_pkg;

   // ALU operation codes
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

endpackage : cpu_pkg

// File: rtl/muldiv_iter_core.sv
// One iteration of the multiply/divide datapath (combinational only).
// The accumulator is {hi[WIDTH:0], lo[WIDTH-1:0]}.
//   Multiply (radix-2 Booth): hi = partial product, lo = remaining multiplier
//     bits, booth = the previously shifted-out multiplier bit. hi carries one
//     guard bit so that adding/subtracting the most negative multiplicand
//     cannot overflow.
//   Divide (restoring): hi = partial remainder, lo = dividend bits shifting
//     out while quotient bits shift in.
// Ports:
//   is_mul_i : 1 = Booth step, 0 = restoring-divide step
//   acc_i    : current accumulator (2*WIDTH+1 bits)
//   booth_i  : Booth appended bit q[-1]
//   m_i      : multiplicand (signed) or divisor magnitude (unsigned)
//   acc_o    : accumulator after this iteration
//   booth_o  : Booth appended bit after this iteration
module muldiv_iter_core
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               is_mul_i,
   input  logic [2*WIDTH:0]   acc_i,
   input  logic               booth_i,
   input  logic [WIDTH-1:0]   m_i,
   output logic [2*WIDTH:0]   acc_o,
   output logic               booth_o
);

   logic [WIDTH:0] hi;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   assign hi = acc_i[2*WIDTH:WIDTH];

   // Remainder shifted left with the next dividend bit brought in, and the
   // trial subtraction of the (zero-extended) divisor magnitude.
   assign rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
   assign trial  = rem_sh - {1'b0, m_i};

   // NOTE: every output of an always_comb block gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      sum     = hi;
      acc_o   = acc_i;
      booth_o = booth_i;
      if (is_mul_i) begin
         unique case ({acc_i[0], booth_i})
            2'b01:   sum = hi + {m_i[WIDTH-1], m_i};
            2'b10:   sum = hi - {m_i[WIDTH-1], m_i};
            default: sum = hi;
         endcase
         // Arithmetic right shift of {sum, lo}; the dropped bit becomes q[-1].
         acc_o   = {sum[WIDTH], sum, acc_i[WIDTH-1:1]};
         booth_o = acc_i[0];
      end else begin
         // Non-negative trial means the divisor fits: keep it, quotient bit 1.
         if (!trial[WIDTH]) begin
            acc_o = {trial, acc_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {acc_i[2*WIDTH-1:0], 1'b0};
         end
         booth_o = 1'b0;
      end
   end

endmodule : muldiv_iter_core

// File: rtl/muldiv_seq_unit.sv
// Iterative signed multiply/divide unit for the Z register pair.
// Fixed latency: start accepted at edge t, done high in the cycle after edge
// t+WIDTH+1, regardless of operands.
// Ports:
//   clock    : rising-edge clock
//   clear    : asynchronous active-low reset
//   start    : request, sampled only while idle
//   alu_op   : OP_MUL or OP_DIV; any other code is ignored
//   a_in     : Y operand (multiplicand / dividend)
//   b_in     : bus operand (multiplier / divisor)
//   z_out    : MUL {prod_hi, prod_lo}; DIV {remainder, quotient}
//   busy     : operation in progress
//   done     : one-cycle pulse, z_out valid
//   div_zero : divide with zero divisor (qualified by done)
module muldiv_seq_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 start,
   input  logic [4:0]           alu_op,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic [2*WIDTH-1:0]   z_out,
   output logic                 busy,
   output logic                 done,
   output logic                 div_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH:0]      acc_q, acc_d;
   logic                  booth_q, booth_d;
   logic [WIDTH-1:0]      m_q, m_d;
   logic [WIDTH-1:0]      a_q, a_d;
   logic                  is_mul_q, is_mul_d;
   logic                  sign_a_q, sign_a_d;
   logic                  sign_b_q, sign_b_d;
   logic                  b_zero_q, b_zero_d;
   logic [2*WIDTH-1:0]    z_q, z_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  div_zero_q, div_zero_d;

   logic [2*WIDTH:0]      acc_step;
   logic                  booth_step;
   logic [WIDTH-1:0]      quo_mag;
   logic [WIDTH-1:0]      rem_mag;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      // The most negative value maps to itself, which is its correct
      // unsigned magnitude.
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   muldiv_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .is_mul_i (is_mul_q),
      .acc_i    (acc_q),
      .booth_i  (booth_q),
      .m_i      (m_q),
      .acc_o    (acc_step),
      .booth_o  (booth_step)
   );

   assign quo_mag = acc_q[WIDTH-1:0];
   assign rem_mag = acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      booth_d    = booth_q;
      m_d        = m_q;
      a_d        = a_q;
      is_mul_d   = is_mul_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      b_zero_d   = b_zero_q;
      z_d        = z_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start && (alu_op == OP_MUL || alu_op == OP_DIV)) begin
               is_mul_d = (alu_op == OP_MUL);
               a_d      = a_in;
               sign_a_d = a_in[WIDTH-1];
               sign_b_d = b_in[WIDTH-1];
               b_zero_d = (b_in == '0);
               booth_d  = 1'b0;
               cnt_d    = CNT_LAST;
               busy_d   = 1'b1;
               state_d  = ST_RUN;
               if (alu_op == OP_MUL) begin
                  m_d   = a_in;
                  acc_d = {{(WIDTH+1){1'b0}}, b_in};
               end else begin
                  m_d   = magnitude(b_in);
                  acc_d = {{(WIDTH+1){1'b0}}, magnitude(a_in)};
               end
            end
         end

         ST_RUN: begin
            acc_d   = acc_step;
            booth_d = booth_step;
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_FIX: begin
            if (is_mul_q) begin
               z_d        = acc_q[2*WIDTH-1:0];
               div_zero_d = 1'b0;
            end else if (b_zero_q) begin
               z_d        = {a_q, {WIDTH{1'b1}}};
               div_zero_d = 1'b1;
            end else begin
               // Truncating division: remainder follows the dividend's sign.
               z_d[2*WIDTH-1:WIDTH] = sign_a_q ? (~rem_mag + 1'b1) : rem_mag;
               z_d[WIDTH-1:0]       = (sign_a_q ^ sign_b_q) ? (~quo_mag + 1'b1) : quo_mag;
               div_zero_d           = 1'b0;
            end
            done_d  = 1'b1;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         booth_q    <= 1'b0;
         m_q        <= '0;
         a_q        <= '0;
         is_mul_q   <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         b_zero_q   <= 1'b0;
         z_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         booth_q    <= booth_d;
         m_q        <= m_d;
         a_q        <= a_d;
         is_mul_q   <= is_mul_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         b_zero_q   <= b_zero_d;
         z_q        <= z_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign z_out    = z_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;

endmodule : muldiv_seq_unit

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: hand-computed results, fixed latency,
// ignored starts, invalid opcodes and asynchronous clear mid-operation.
module tb_muldiv_seq_unit;
   import cpu_pkg::*;

   localparam int WIDTH = 32;
   // done is visible in the cycle after edge t+WIDTH+1 (t = accept edge),
   // i.e. on the WIDTH+1'th falling-edge sample after the accept edge.
   localparam int DONE_EDGES = WIDTH + 1;
   localparam int WATCH      = 45;

   logic                 clock = 1'b0;
   logic                 clear = 1'b0;
   logic                 start = 1'b0;
   logic [4:0]           alu_op = OP_LD;
   logic [WIDTH-1:0]     a_in = '0;
   logic [WIDTH-1:0]     b_in = '0;
   logic [2*WIDTH-1:0]   z_out;
   logic                 busy;
   logic                 done;
   logic                 div_zero;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_seq_unit #(
      .WIDTH (WIDTH)
   ) dut (
      .clock    (clock),
      .clear    (clear),
      .start    (start),
      .alu_op   (alu_op),
      .a_in     (a_in),
      .b_in     (b_in),
      .z_out    (z_out),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Issue one operation and watch a fixed window. Optionally inject extra
   // starts with different operands while the unit is running.
   task automatic run_op(input string name, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_z, input logic exp_dz,
                         input bit inject);
      int lat    = 0;
      int pulses = 0;
      @(negedge clock);
      start  = 1'b1;
      alu_op = op;
      a_in   = a;
      b_in   = b;
      @(negedge clock);
      // Change operands right after accept: they must not be re-sampled.
      start = 1'b0;
      a_in  = 32'hDEAD_BEEF;
      b_in  = 32'h1234_5678;
      check({name, " busy"}, 64'(busy), 64'd1);
      for (int n = 1; n <= WATCH; n++) begin
         @(negedge clock);
         if (done) begin
            pulses++;
            if (lat == 0) begin
               lat = n;
               check({name, " z_out"}, z_out, exp_z);
               check({name, " div_zero"}, 64'(div_zero), 64'(exp_dz));
            end
         end
         if (inject && (n == 5 || n == 20)) begin
            start  = 1'b1;
            alu_op = OP_MUL;
            a_in   = 32'h0000_0011;
            b_in   = 32'h0000_0022;
         end else begin
            start = 1'b0;
         end
      end
      check({name, " latency"}, 64'(lat), 64'(DONE_EDGES));
      check({name, " done pulses"}, 64'(pulses), 64'd1);
      check({name, " z hold"}, z_out, exp_z);
      check({name, " busy idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int pulses;
      logic busy_seen;

      // Reset state
      repeat (2) @(negedge clock);
      check("reset z_out", z_out, 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset div_zero", 64'(div_zero), 64'd0);
      clear = 1'b1;

      // Multiply
      run_op("mul 7*-3",   OP_MUL, 32'd7,         32'hFFFF_FFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b0);
      run_op("mul min*min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 1'b0, 1'b0);
      run_op("mul -1*-1",  OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000000_00000001, 1'b0, 1'b0);

      // Divide
      run_op("div -7/2",   OP_DIV, 32'hFFFF_FFF9, 32'd2,         64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0);
      run_op("div 7/-2",   OP_DIV, 32'd7,         32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0, 1'b0);
      run_op("div 100/7",  OP_DIV, 32'd100,       32'd7,         64'h00000002_0000000E, 1'b0, 1'b0);
      run_op("div 100/0",  OP_DIV, 32'd100,       32'd0,         64'h00000064_FFFFFFFF, 1'b1, 1'b0);
      run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0, 1'b0);

      // Starts during a running MUL are ignored
      run_op("mul ignore", OP_MUL, 32'd7,         32'hFFFF_FFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b1);

      // Invalid opcode: nothing starts
      @(negedge clock);
      start  = 1'b1;
      alu_op = OP_ADD;
      a_in   = 32'd5;
      b_in   = 32'd6;
      @(negedge clock);
      start = 1'b0;
      busy_seen = busy;
      repeat (3) begin
         @(negedge clock);
         busy_seen = busy_seen | busy;
      end
      check("bad op busy", 64'(busy_seen), 64'd0);

      // Clear in the middle of a divide
      @(negedge clock);
      start  = 1'b1;
      alu_op = OP_DIV;
      a_in   = 32'd100;
      b_in   = 32'd7;
      @(negedge clock);
      start = 1'b0;
      repeat (14) @(negedge clock);
      #2 clear = 1'b0;
      #1;
      check("clear z_out", z_out, 64'd0);
      check("clear busy", 64'(busy), 64'd0);
      check("clear done", 64'(done), 64'd0);
      check("clear div_zero", 64'(div_zero), 64'd0);
      pulses = 0;
      repeat (2) @(negedge clock);
      clear = 1'b1;
      repeat (WATCH) begin
         @(negedge clock);
         if (done) pulses++;
      end
      check("clear no done", 64'(pulses), 64'd0);

      run_op("mul 3*4",    OP_MUL, 32'd3,         32'd4,         64'h00000000_0000000C, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_muldiv_seq_unit

// File: doc/muldiv_seq_unit.md
# muldiv_seq_unit

Iterative signed multiply/divide stage that runs alongside the combinational ALU, taking the Y-register operand and the bus operand and producing a 64-bit result for the Z register pair (high word to ZHigh, low word to ZLow). The combinational `*` and `/` paths are removed from the ALU. The control unit issues `start` with the ALU operation code, waits for `done`, then asserts the Z-in strobes.

## Interface
- `WIDTH`, 32: operand width. The result is 2*WIDTH bits.
- `clock` input, 1 bit: the single clock, rising edge.
- `clear` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request. Sampled only in IDLE.
- `alu_op` input, 5 bits: operation code, same encoding as the ALU control field.
  - 5'b01111 is multiply.
  - 5'b10000 is divide.
- `a_in` input, WIDTH bits: Y-register operand (multiplicand or dividend).
- `b_in` input, WIDTH bits: bus operand (multiplier or divisor).
- `z_out` output, 2*WIDTH bits.
  - Multiply: {product_hi, product_lo}.
  - Divide: {remainder, quotient}.
- `busy` output, 1 bit: high from the cycle after accept until `done` deasserts.
- `done` output, 1 bit: one-cycle pulse. `z_out` is valid in this cycle.
- `div_zero` output, 1 bit: qualified by `done`; set when a divide had b_in == 0.

## Operation
- FSM states are IDLE, RUN, FIX and DONE.
- IDLE:
  - `start`=1 with a valid `alu_op`: latch a_in, b_in, op and operand signs. Load the iteration counter to WIDTH-1. Go to RUN.
  - `start` with any other `alu_op` is ignored (stay in IDLE, no flags).
- RUN: one iteration per cycle for WIDTH cycles. Counter decrements; at 0, go to FIX.
  - Multiply: radix-2 Booth recoding on a 2*WIDTH+1-bit accumulator, arithmetic right shift each step. The product is the exact signed 64-bit value.
  - Divide: restoring division on operand magnitudes, producing one quotient bit per cycle.
- FIX:
  - Divide: negate the quotient if the operand signs differ. The remainder takes the dividend's sign, so division truncates toward zero.
  - Multiply: pass-through. Register `z_out`. Go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `z_out` and `div_zero` hold until the next accepted start. They do not clear on return to IDLE.
- Divide by zero runs the full latency, then forces `z_out` = {a_in, {WIDTH{1'b1}}} and `div_zero`=1.
- Overflow case 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0, `div_zero`=0.
- `start` during RUN, FIX or DONE is ignored. Operands are not re-sampled.

## Timing
- Reset (`clear`=0, asynchronous): state to IDLE, counter to 0, `z_out` to 0, `busy` to 0, `done` to 0, `div_zero` to 0. Reset mid-operation discards work; no `done` is issued.
- Start is accepted at rising edge t. `busy`=1 from t until the edge that ends DONE.
- RUN spans edges t+1 through t+WIDTH. FIX is at edge t+WIDTH+1.
- `done` is high in the cycle following edge t+WIDTH+1, i.e. a fixed latency of WIDTH+2 = 34 cycles from accept. Latency does not depend on operands or on divide-by-zero.
- Back-to-back: `start` is accepted at the first edge where the state is IDLE, one cycle after `done`. Minimum issue interval is 35 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `cpu_pkg` holds:
  - ALU operation-code constants (OP_MUL = 5'b01111, OP_DIV = 5'b10000, plus the existing ALU codes). The ALU and this block both import them.
  - The FSM state enum.
- Natural sub-module `muldiv_iter_core`: the per-cycle Booth add/sub-shift and the restoring subtract-shift datapath. It is combinational next-value logic only, with registers in the parent.
- The parent holds the FSM, counter, operand and sign latches, sign fix, and output registers.

## Test plan
- MUL 7 × -3 (b_in=0xFFFFFFFD) → `done` at cycle 34, `z_out`=64'hFFFFFFFF_FFFFFFEB, `div_zero`=0.
- MUL 0x80000000 × 0x80000000 → `z_out`=64'h40000000_00000000. MUL 0xFFFFFFFF × 0xFFFFFFFF → 64'h00000000_00000001.
- DIV -7 / 2 → `z_out`=64'hFFFFFFFF_FFFFFFFD (remainder -1, quotient -3). DIV 100 / 7 → 64'h00000002_0000000E.
- DIV 100 / 0 → `z_out`=64'h00000064_FFFFFFFF, `div_zero`=1 with `done` at cycle 34. DIV 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000, `div_zero`=0.
- `start` pulsed at cycles 5 and 20 of a running MUL with new operands → only the first result appears and `done` pulses once. A `start` with `alu_op`=5'b00011 → `busy` stays 0.
- `clear` low at cycle 15 of a DIV → all outputs 0 immediately with no `done`. A new MUL 3 × 4 issued after release → `z_out`=64'h00000000_0000000C at cycle 34.
